fim_wrack_scfifo: RTL and testbench
===================================

Name: fim_wrack_scfifo

Overview:
Single-clock FIFO with a write-acknowledge producer interface. The producer presents wdata/wvalid and holds them until the FIFO returns wack. The consumer side is a conventional rdreq/rvalid pop port with registered read data. It is the write-side counterpart of the rdack FIFO and sits between a data source that cannot tolerate drops and a consumer that pops on demand.

Parameters:
DATA_WIDTH, 32, width of wdata/rdata.
DEPTH_LOG2, 5, FIFO holds 2**DEPTH_LOG2 entries; DEPTH_LOG2 >= 1.
ALMOST_FULL_THRESHOLD, 2**(DEPTH_LOG2-1), almfull asserts when usedw >= this value; range 1..2**DEPTH_LOG2.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
wdata  in  DATA_WIDTH  write data; producer holds it stable while wvalid=1 and wack=0.
wvalid  in  1  producer has data to write.
wack  out  1  write accepted this cycle.
rdreq  in  1  pop request.
rdata  out  DATA_WIDTH  popped data, registered.
rvalid  out  1  rdata valid, one-cycle pulse per pop.
usedw  out  DEPTH_LOG2+1  entries currently stored, 0..2**DEPTH_LOG2.
wfull  out  1  usedw == 2**DEPTH_LOG2.
almfull  out  1  usedw >= ALMOST_FULL_THRESHOLD.
rempty  out  1  usedw == 0.
err_rd_empty  out  1  sticky; set when rdreq=1 while rempty=1.

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, usedw=0, rvalid=0, rdata=0, err_rd_empty=0. Outputs then read wfull=0, rempty=1, almfull=0. Storage array is not reset. Release is synchronous to clk.
- Storage: circular array of 2**DEPTH_LOG2 entries. wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap naturally from 2**DEPTH_LOG2-1 to 0.
- Write acceptance: wack = wvalid & ~wfull, combinational from registered state.
  - On a clock edge with wack=1: mem[wr_ptr] <= wdata, wr_ptr++.
  - wack never depends on rdreq. A write into a full FIFO is refused even if a pop occurs in the same cycle.
- Pop: pop = rdreq & ~rempty.
  - On a clock edge with pop=1: rdata <= mem[rd_ptr], rd_ptr++, rvalid <= 1.
  - Otherwise rvalid <= 0 and rdata holds its last value.
  - Latency is one cycle from rdreq to rvalid. There is no show-ahead.
- Empty read: rdreq=1 with rempty=1 produces no pop and no pointer change, sets err_rd_empty=1, and leaves rvalid=0. err_rd_empty clears only on reset.
- Simultaneous write and read on an empty FIFO: the write is accepted and the pop is refused, because rempty is evaluated before the write. usedw becomes 1 and err_rd_empty is set.
- Simultaneous write and pop on a non-empty, non-full FIFO: both occur and usedw is unchanged.
- Counter update: usedw <= usedw + wack − pop.
  - The counter is DEPTH_LOG2+1 bits, so it never wraps.
  - wfull, rempty and almfull decode combinationally from usedw. They change in the cycle after the causing edge.
- Write-to-read turnaround: data written at edge N is poppable at edge N+1, when rempty has deasserted. It appears on rdata after edge N+1.
- Reset mid-operation: all queued data is discarded. Any wvalid pending at reset is not acknowledged until after release.
- Producer protocol: the producer must not change wdata while wvalid=1 and wack=0. If wvalid drops without wack, no write occurs.

Test Plan (DEPTH_LOG2=2, ALMOST_FULL_THRESHOLD=2, DATA_WIDTH=8):
- Reset then idle -> rempty=1, wfull=0, almfull=0, usedw=0, rvalid=0, rdata=0, wack=0.
- Hold wvalid=1 with wdata 0x11,0x22,0x33,0x44,0x55 (advance only on wack) and no reads -> wack on the first 4 cycles, usedw 1,2,3,4. almfull rises after the 2nd write and wfull after the 4th. 0x55 is held with wack=0.
- FIFO full with 0x55 pending, rdreq=1 for one cycle -> 0x55 not accepted that cycle, rdata=0x11 with rvalid=1 next cycle, usedw=3. 0x55 is accepted the following cycle and usedw returns to 4.
- Drain with rdreq=1 continuously -> rdata 0x22,0x33,0x44,0x55 on consecutive rvalid pulses. rempty=1 after the last pop, with the pointers having wrapped past entry 3.
- Empty FIFO, wvalid=1 (0xA5) and rdreq=1 in the same cycle -> wack=1, no rvalid, err_rd_empty=1, usedw=1. rdreq next cycle gives rdata=0xA5 and rvalid=1.
- Steady state with usedw=2, wvalid=1 and rdreq=1 for 10 cycles -> usedw stays 2 and data emerges in write order. Asserting rst_n=0 mid-stream immediately gives usedw=0, rvalid=0 and err_rd_empty=0.

Source files
------------

// File: rtl/fim_wrack_scfifo.sv
// Single-clock FIFO with a write-acknowledge producer port and a registered
// rdreq/rvalid pop port. Status flags decode combinationally from usedw.
module fim_wrack_scfifo #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned DEPTH_LOG2            = 5,
  parameter int unsigned ALMOST_FULL_THRESHOLD = 2**(DEPTH_LOG2-1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wack,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [DEPTH_LOG2:0]   usedw,
  output logic                  wfull,
  output logic                  almfull,
  output logic                  rempty,
  output logic                  err_rd_empty
);

  localparam int unsigned DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_CNT   = (DEPTH_LOG2+1)'(ALMOST_FULL_THRESHOLD);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   usedw_q, usedw_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  pop;

  assign wfull   = (usedw_q == FULL_CNT);
  assign rempty  = (usedw_q == '0);
  assign almfull = (usedw_q >= AF_CNT);

  // rst_n gating keeps a producer held at wvalid from seeing an acknowledge
  // while the FIFO is held in reset (no write can land then anyway).
  assign wack = wvalid & ~wfull & rst_n;
  assign pop  = rdreq & ~rempty;

  assign usedw        = usedw_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign err_rd_empty = err_q;

  // Next-state for pointers, occupancy, read data and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = err_q;
    if (wack) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem[rd_ptr_q];
      rvalid_d = 1'b1;
    end
    if (rdreq && rempty) err_d = 1'b1;
    usedw_d = usedw_q + (DEPTH_LOG2+1)'(wack) - (DEPTH_LOG2+1)'(pop);
  end

  // Control and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Storage array; not reset.
  always_ff @(posedge clk) begin
    if (wack) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: tb/tb_fim_wrack_scfifo.sv
// Directed, table-driven bench for fim_wrack_scfifo (8-bit, 4 entries, almfull at 2).
module tb_fim_wrack_scfifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wack;
  logic       rdreq;
  logic [7:0] rdata;
  logic       rvalid;
  logic [2:0] usedw;
  logic       wfull, almfull, rempty, err_rd_empty;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rd;
    logic       e_wack;
    logic [2:0] e_usedw;
    logic       e_rvalid;
    logic [7:0] e_rdata;
    logic       e_wfull;
    logic       e_almfull;
    logic       e_rempty;
    logic       e_err;
  } vec_t;

  vec_t tbl [13];

  fim_wrack_scfifo #(
    .DATA_WIDTH           (8),
    .DEPTH_LOG2           (2),
    .ALMOST_FULL_THRESHOLD(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wdata       (wdata),
    .wvalid      (wvalid),
    .wack        (wack),
    .rdreq       (rdreq),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .usedw       (usedw),
    .wfull       (wfull),
    .almfull     (almfull),
    .rempty      (rempty),
    .err_rd_empty(err_rd_empty)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic wv, logic [7:0] wd, logic rd, logic wk,
                              logic [2:0] u, logic rv, logic [7:0] rdt,
                              logic wf, logic af, logic re, logic er);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rd = rd; v.e_wack = wk; v.e_usedw = u;
    v.e_rvalid = rv; v.e_rdata = rdt; v.e_wfull = wf; v.e_almfull = af;
    v.e_rempty = re; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, id, act, exp);
    end
  endtask

  task automatic chk_state(input int id, input vec_t v);
    chk("usedw",   id, 32'(usedw),        32'(v.e_usedw));
    chk("rvalid",  id, 32'(rvalid),       32'(v.e_rvalid));
    chk("rdata",   id, 32'(rdata),        32'(v.e_rdata));
    chk("wfull",   id, 32'(wfull),        32'(v.e_wfull));
    chk("almfull", id, 32'(almfull),      32'(v.e_almfull));
    chk("rempty",  id, 32'(rempty),       32'(v.e_rempty));
    chk("err",     id, 32'(err_rd_empty), 32'(v.e_err));
  endtask

  // Drive one cycle: wack is checked before the edge, registered state after.
  task automatic step(input int id, input vec_t v);
    n_vec++;
    wvalid = v.wv;
    wdata  = v.wd;
    rdreq  = v.rd;
    #1;
    chk("wack", id, 32'(wack), 32'(v.e_wack));
    @(posedge clk);
    #1;
    chk_state(id, v);
  endtask

  initial begin
    //                wv  wd     rd   wack u     rv  rdata  wf  af  re  er
    tbl[0]  = mk(1'b1, 8'h11, 1'b0, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 8'h22, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 8'h33, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 8'h44, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 8'h55, 1'b0, 1'b0, 3'd4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 8'h55, 1'b1, 1'b0, 3'd3, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 8'h55, 1'b0, 1'b1, 3'd4, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 8'hA5, 1'b1, 1'b1, 3'd1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset, idle.
    rst_n  = 1'b0;
    wvalid = 1'b0;
    wdata  = '0;
    rdreq  = 1'b0;
    #12;
    n_vec++;
    chk("rst_wack", -1, 32'(wack), 32'd0);
    chk_state(-1, mk(1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b1;

    // Fill past full, pop while full with a pending write, drain, empty read+write.
    for (int i = 0; i < 13; i++) step(i, tbl[i]);

    // Build occupancy 2, then simultaneous write/pop for 10 cycles.
    step(100, mk(1'b1, 8'h60, 1'b0, 1'b1, 3'd1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1));
    step(101, mk(1'b1, 8'h61, 1'b0, 1'b1, 3'd2, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++)
      step(200 + i, mk(1'b1, 8'h62 + 8'(i), 1'b1, 1'b1, 3'd2, 1'b1, 8'h60 + 8'(i),
                       1'b0, 1'b1, 1'b0, 1'b1));

    // Asynchronous reset mid-stream with wvalid/rdreq still asserted.
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("midrst_wack", 300, 32'(wack), 32'd0);
    chk_state(300, mk(1'b1, 8'h6C, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    n_vec++;
    chk_state(301, mk(1'b1, 8'h6C, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    rst_n = 1'b1;

    // First write after release is acknowledged.
    step(302, mk(1'b1, 8'h77, 1'b0, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    step(303, mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
